// File: rtl/rom_arbiter_if.sv
// Requester-side bus of the ROM arbiter; one instance per requester port.
// Latency: n/a (wiring only); gnt and rvalid are single-cycle pulses driven by the arbiter.
// Backpressure: the requester holds req/addr until rvalid; no other flow control.
interface rom_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 32
);
  logic          req;
  logic [AW-1:0] addr;
  logic          gnt;
  logic [DW-1:0] rdata;
  logic          rvalid;

  // Requester side: drives the request, observes grant and read data.
  modport master (
    output req,
    output addr,
    input  gnt,
    input  rdata,
    input  rvalid
  );

  // Arbiter side: samples the request, returns grant and read data.
  modport slave (
    input  req,
    input  addr,
    output gnt,
    output rdata,
    output rvalid
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin two-port arbiter/sequencer in front of the shared instruction ROM.
// Latency: gnt one cycle after the sampling edge, rvalid ROM_LAT+1 cycles after it; ROM_LAT+2 cycles per access.
// Backpressure: a port simply waits with req high while the other port is being served; no queuing.
module rom_arbiter #(
  parameter int AW      = 16,
  parameter int DW      = 32,
  parameter int ROM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  rom_arbiter_if.slave  m0,
  rom_arbiter_if.slave  m1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  // The 4-bit wait counter only covers 1..15 cycles of ROM latency.
  generate
    if (ROM_LAT < 1 || ROM_LAT > 15) begin : g_bad_lat
      $fatal(1, "rom_arbiter: ROM_LAT must be in 1..15");
    end
  endgenerate

  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          owner;
  logic          last_owner;
  logic          gnt0, gnt1;
  logic          rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          pick1;

  // Port 1 wins when it is the only requester, or on a tie when port 0 was served last.
  assign pick1 = m1.req & (~m0.req | ~last_owner);

  assign busy      = (state != IDLE);
  assign m0.gnt    = gnt0;
  assign m1.gnt    = gnt1;
  assign m0.rvalid = rvalid0;
  assign m1.rvalid = rvalid1;
  assign m0.rdata  = rdata0;
  assign m1.rdata  = rdata1;

  // Access sequencer: arbitrate in IDLE, count down the ROM latency, then pulse rvalid once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      rom_addr   <= '0;
    end else begin
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      case (state)
        IDLE: begin
          if (m0.req || m1.req) begin
            rom_addr   <= pick1 ? m1.addr : m0.addr;
            owner      <= pick1;
            last_owner <= pick1;
            cnt        <= 4'(ROM_LAT);
            gnt0       <= ~pick1;
            gnt1       <= pick1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          // Only the final wait edge samples the ROM; earlier rom_data may still be settling.
          if (cnt == 4'd1) begin
            if (owner) begin
              rdata1  <= rom_data;
              rvalid1 <= 1'b1;
            end else begin
              rdata0  <= rom_data;
              rvalid0 <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          // Requester updates req on this edge, so IDLE only sees post-response requests.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: one ROM_LAT=1 instance and one ROM_LAT=3 instance.
// Expected read results are queued when a request is driven and popped when rvalid appears.
// Outputs are sampled on the falling edge; inputs are driven on the falling edge.
module tb_rom_arbiter;
  logic        clk = 1'b0;
  logic        rst1_n, rst3_n;
  logic [15:0] rom_addr1, rom_addr3;
  logic [31:0] rom_data1, rom_data3;
  logic        busy1, busy3;
  logic        rom3_ok;
  logic [15:0] garb = 16'h0;
  int          total = 0;
  int          bad = 0;
  int          gc0 = 0;
  int          gc1 = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;

  exp_t sb1[$];
  exp_t sb3[$];

  rom_arbiter_if #(.AW(16), .DW(32)) i0 ();
  rom_arbiter_if #(.AW(16), .DW(32)) i1 ();
  rom_arbiter_if #(.AW(16), .DW(32)) j0 ();
  rom_arbiter_if #(.AW(16), .DW(32)) j1 ();

  rom_arbiter #(.AW(16), .DW(32), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .m0(i0.slave), .m1(i1.slave),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .busy(busy1)
  );

  rom_arbiter #(.AW(16), .DW(32), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst3_n), .m0(j0.slave), .m1(j1.slave),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .busy(busy3)
  );

  always #5 clk = ~clk;

  // ROM models; the latency-3 ROM returns garbage unless the bench marks the sampling window.
  assign rom_data1 = {16'hA5A5, rom_addr1};
  assign rom_data3 = rom3_ok ? {16'hA5A5, rom_addr3} : {16'h5A5A, garb};

  always @(negedge clk) garb = 16'($urandom);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input int d, input int p, input logic r, input logic [15:0] a);
    if (d == 1) begin
      if (p == 0) begin i0.req = r; i0.addr = a; end
      else        begin i1.req = r; i1.addr = a; end
    end else begin
      if (p == 0) begin j0.req = r; j0.addr = a; end
      else        begin j1.req = r; j1.addr = a; end
    end
  endtask

  function automatic logic rv(input int d, input int p);
    if (d == 1) return (p == 0) ? i0.rvalid : i1.rvalid;
    return (p == 0) ? j0.rvalid : j1.rvalid;
  endfunction

  task automatic rst_pulse(input int d);
    @(negedge clk);
    if (d == 1) rst1_n = 1'b0; else rst3_n = 1'b0;
    #2;
    if (d == 1) rst1_n = 1'b1; else rst3_n = 1'b1;
  endtask

  // Requester: n reads from consecutive addresses, next address presented on each rvalid.
  task automatic serve(input int d, input int p, input logic [15:0] a0, input int n);
    for (int k = 0; k < n; k++) begin
      int w;
      w = 0;
      drive(d, p, 1'b1, a0 + 16'(k));
      do begin
        @(negedge clk);
        w++;
      end while (!rv(d, p) && w < 40);
      if (!rv(d, p)) begin
        total++;
        bad++;
        $display("FAIL serve_timeout d=%0d p=%0d: got=no rvalid exp=rvalid", d, p);
      end
    end
    drive(d, p, 1'b0, a0);
  endtask

  // Scoreboard for the latency-1 instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (i0.gnt) gc0++;
    if (i1.gnt) gc1++;
    if (i0.gnt || i1.gnt) check("d1_gnt_excl", {31'd0, i0.gnt & i1.gnt}, 32'd0);
    if (i0.rvalid || i1.rvalid) begin
      check("d1_rv_excl", {31'd0, i0.rvalid & i1.rvalid}, 32'd0);
      if (sb1.size() == 0) begin
        total++;
        bad++;
        $display("FAIL d1_sb: got=unexpected rvalid exp=none");
      end else begin
        e = sb1.pop_front();
        check("d1_port", {31'd0, i1.rvalid}, e.port);
        check("d1_rdata", i1.rvalid ? i1.rdata : i0.rdata, e.data);
      end
    end
  end

  // Scoreboard for the latency-3 instance.
  always @(negedge clk) begin : mon3
    exp_t e;
    if (j0.gnt || j1.gnt) check("d3_gnt_excl", {31'd0, j0.gnt & j1.gnt}, 32'd0);
    if (j0.rvalid || j1.rvalid) begin
      check("d3_rv_excl", {31'd0, j0.rvalid & j1.rvalid}, 32'd0);
      if (sb3.size() == 0) begin
        total++;
        bad++;
        $display("FAIL d3_sb: got=unexpected rvalid exp=none");
      end else begin
        e = sb3.pop_front();
        check("d3_port", {31'd0, j1.rvalid}, e.port);
        check("d3_rdata", j1.rvalid ? j1.rdata : j0.rdata, e.data);
      end
    end
  end

  initial begin
    rst1_n  = 1'b0;
    rst3_n  = 1'b0;
    rom3_ok = 1'b1;
    drive(1, 0, 1'b0, 16'h0); drive(1, 1, 1'b0, 16'h0);
    drive(3, 0, 1'b0, 16'h0); drive(3, 1, 1'b0, 16'h0);

    // Reset held while requests toggle
    repeat (3) begin
      @(negedge clk);
      drive(1, 0, ~i0.req, 16'h0055);
      drive(1, 1, ~i1.req, 16'h0066);
    end
    @(negedge clk);
    check("rst_pulses", {28'd0, i0.gnt, i1.gnt, i0.rvalid, i1.rvalid}, 32'd0);
    check("rst_rom_addr", {16'd0, rom_addr1}, 32'd0);
    check("rst_rdata0", i0.rdata, 32'd0);
    check("rst_rdata1", i1.rdata, 32'd0);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    drive(1, 0, 1'b0, 16'h0); drive(1, 1, 1'b0, 16'h0);
    rst1_n = 1'b1;

    // Asynchronous reset in the middle of an access clears outputs without a clock edge
    @(negedge clk); drive(1, 0, 1'b1, 16'h0007);
    @(negedge clk);
    check("arst_pre_gnt", {31'd0, i0.gnt}, 32'd1);
    #2 rst1_n = 1'b0;
    #1;
    check("arst_gnt", {31'd0, i0.gnt}, 32'd0);
    check("arst_busy", {31'd0, busy1}, 32'd0);
    check("arst_rom_addr", {16'd0, rom_addr1}, 32'd0);
    drive(1, 0, 1'b0, 16'h0);
    @(negedge clk); rst1_n = 1'b1;

    // Single access on port 0
    @(negedge clk); drive(1, 0, 1'b1, 16'h0004); sb1.push_back('{0, 32'hA5A50004});
    @(negedge clk);
    check("t2_gnt0", {31'd0, i0.gnt}, 32'd1);
    check("t2_gnt1", {31'd0, i1.gnt}, 32'd0);
    check("t2_rom_addr", {16'd0, rom_addr1}, 32'h0004);
    check("t2_busy_c1", {31'd0, busy1}, 32'd1);
    check("t2_rv_early", {31'd0, i0.rvalid}, 32'd0);
    @(negedge clk);
    check("t2_rvalid", {31'd0, i0.rvalid}, 32'd1);
    check("t2_busy_c2", {31'd0, busy1}, 32'd1);
    check("t2_gnt_pulse", {31'd0, i0.gnt}, 32'd0);
    drive(1, 0, 1'b0, 16'h0004);
    @(negedge clk);
    check("t2_rv_pulse", {31'd0, i0.rvalid}, 32'd0);
    check("t2_rdata_hold", i0.rdata, 32'hA5A50004);
    check("t2_m1_rdata", i1.rdata, 32'd0);
    check("t2_busy_idle", {31'd0, busy1}, 32'd0);

    // Tie right after reset: port 0 first, then port 1
    rst_pulse(1);
    @(negedge clk);
    drive(1, 0, 1'b1, 16'h0010); drive(1, 1, 1'b1, 16'h0020);
    sb1.push_back('{0, 32'hA5A50010}); sb1.push_back('{1, 32'hA5A50020});
    @(negedge clk);
    check("t3_gnt0", {31'd0, i0.gnt}, 32'd1);
    check("t3_gnt1_c1", {31'd0, i1.gnt}, 32'd0);
    @(negedge clk);
    check("t3_rv0", {31'd0, i0.rvalid}, 32'd1);
    drive(1, 0, 1'b0, 16'h0010);
    @(negedge clk);
    check("t3_gnt1_c3", {31'd0, i1.gnt}, 32'd0);
    @(negedge clk);
    check("t3_gnt1_c4", {31'd0, i1.gnt}, 32'd1);
    check("t3_rom_addr", {16'd0, rom_addr1}, 32'h0020);
    @(negedge clk);
    check("t3_rv1", {31'd0, i1.rvalid}, 32'd1);
    check("t3_rdata0_kept", i0.rdata, 32'hA5A50010);
    drive(1, 1, 1'b0, 16'h0020);

    // Continuous contention: strict alternation starting with port 0
    rst_pulse(1);
    gc0 = 0; gc1 = 0;
    for (int k = 0; k < 4; k++) begin
      sb1.push_back('{0, {16'hA5A5, 16'h0100 + 16'(k)}});
      sb1.push_back('{1, {16'hA5A5, 16'h0200 + 16'(k)}});
    end
    fork
      serve(1, 0, 16'h0100, 4);
      serve(1, 1, 16'h0200, 4);
    join
    @(negedge clk);
    check("t4_gnt_cnt0", gc0, 32'd4);
    check("t4_gnt_cnt1", gc1, 32'd4);
    check("t4_sb_drained", sb1.size(), 32'd0);

    // Address change after sampling is ignored; a short req pulse is never granted
    rst_pulse(1);
    @(negedge clk); drive(1, 0, 1'b1, 16'h0040); sb1.push_back('{0, 32'hA5A50040});
    @(negedge clk);
    check("t7_gnt0", {31'd0, i0.gnt}, 32'd1);
    drive(1, 0, 1'b1, 16'h1234);
    @(negedge clk);
    check("t7_rv0", {31'd0, i0.rvalid}, 32'd1);
    check("t7_rom_addr", {16'd0, rom_addr1}, 32'h0040);
    drive(1, 0, 1'b0, 16'h1234);
    @(negedge clk);
    gc1 = 0;
    drive(1, 1, 1'b1, 16'h0050);
    #2 drive(1, 1, 1'b0, 16'h0050);
    repeat (3) @(negedge clk);
    check("t7_no_gnt1", gc1, 32'd0);
    check("t7_idle", {31'd0, busy1}, 32'd0);
    check("t7_rom_addr_hold", {16'd0, rom_addr1}, 32'h0040);
    check("t7_sb_drained", sb1.size(), 32'd0);

    // Latency 3, port 1 at the top address, ROM valid only on the sampling edge
    rst_pulse(3);
    rom3_ok = 1'b0;
    @(negedge clk); drive(3, 1, 1'b1, 16'hFFFF); sb3.push_back('{1, 32'hA5A5FFFF});
    @(negedge clk);
    check("t5_gnt1", {31'd0, j1.gnt}, 32'd1);
    check("t5_rom_addr", {16'd0, rom_addr3}, 32'h0000FFFF);
    @(negedge clk);
    check("t5_rv_c2", {31'd0, j1.rvalid}, 32'd0);
    @(negedge clk);
    check("t5_rv_c3", {31'd0, j1.rvalid}, 32'd0);
    rom3_ok = 1'b1;
    @(negedge clk);
    rom3_ok = 1'b0;
    check("t5_rv_c4", {31'd0, j1.rvalid}, 32'd1);
    check("t5_busy", {31'd0, busy3}, 32'd1);
    drive(3, 1, 1'b0, 16'hFFFF);
    @(negedge clk);
    check("t5_rdata_hold", j1.rdata, 32'hA5A5FFFF);
    check("t5_m0_quiet", j0.rdata, 32'd0);

    // Reset during WAIT discards the access; then a tie is won by port 0
    rst_pulse(3);
    rom3_ok = 1'b1;
    @(negedge clk); drive(3, 0, 1'b1, 16'h0300);
    @(negedge clk);
    check("t6_gnt0", {31'd0, j0.gnt}, 32'd1);
    @(negedge clk);
    #1 rst3_n = 1'b0;
    #1 check("t6_busy_rst", {31'd0, busy3}, 32'd0);
    drive(3, 0, 1'b0, 16'h0300);
    repeat (4) @(negedge clk);
    check("t6_no_rdata", j0.rdata, 32'd0);
    rst3_n = 1'b1;
    sb3.push_back('{0, 32'hA5A50310}); sb3.push_back('{1, 32'hA5A50320});
    fork
      serve(3, 0, 16'h0310, 1);
      serve(3, 1, 16'h0320, 1);
    join
    @(negedge clk);
    check("t6_sb_drained", sb3.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
